// File: rtl/bram_stream_reader_pkg.sv
// Shared types and constants for the BRAM stream reader.
package bram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } reader_state_e;

    localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/bram_stream_reader_if.sv
// Command, BRAM port-B and output-stream signals of the reader.
interface bram_stream_reader_if #(
    parameter int unsigned LEN_DATA = 32,
    parameter int unsigned LEN_ADDR = 10
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [LEN_ADDR-1:0] cmd_addr;
    logic [LEN_ADDR:0]   cmd_len;
    logic                bram_enb;
    logic [LEN_ADDR-1:0] bram_addrb;
    logic [LEN_DATA-1:0] bram_doutb;
    logic                out_valid;
    logic                out_ready;
    logic [LEN_DATA-1:0] out_data;
    logic                out_last;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, bram_doutb, out_ready,
        output cmd_ready, bram_enb, bram_addrb, out_valid, out_data, out_last
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, bram_doutb, out_ready,
        input  cmd_ready, bram_enb, bram_addrb, out_valid, out_data, out_last
    );
endinterface

// File: rtl/bram_stream_reader_skid_fifo.sv
// Two-entry {last, data} FIFO that catches BRAM read data while the stream is stalled.
module reader_skid_fifo
    import bram_reader_pkg::*;
#(
    parameter int unsigned LEN_DATA = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                push,
    input  logic                push_last,
    input  logic [LEN_DATA-1:0] push_data,
    input  logic                pop,
    output logic                head_valid,
    output logic                head_last,
    output logic [LEN_DATA-1:0] head_data,
    output logic [1:0]          occupancy
);
    logic [LEN_DATA:0] mem [FIFO_DEPTH];
    logic              rd_idx;
    logic              wr_idx;
    logic [1:0]        count;
    logic              pop_eff;

    assign pop_eff = pop && (count != 2'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_idx <= 1'b0;
            wr_idx <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_idx] <= {push_last, push_data};
                wr_idx      <= ~wr_idx;
            end
            if (pop_eff) begin
                rd_idx <= ~rd_idx;
            end
            count <= count + {1'b0, push} - {1'b0, pop_eff};
        end
    end

    assign {head_last, head_data} = mem[rd_idx];
    assign head_valid             = (count != 2'd0);
    assign occupancy              = count;
endmodule

// File: rtl/bram_stream_reader.sv
// Walks BRAM port B for a (base, length) command and streams the words out with valid/ready.
module bram_stream_reader
    import bram_reader_pkg::*;
#(
    parameter int unsigned LEN_DATA = 32,
    parameter int unsigned LEN_ADDR = 10
) (
    input  logic                 clk,
    input  logic                 resetn,
    bram_stream_reader_if.master bus,
    output logic                 busy,
    output logic                 done
);
    localparam logic [LEN_ADDR-1:0] ADDR_ONE = 1;
    localparam logic [LEN_ADDR:0]   CNT_ONE  = 1;

    reader_state_e       state;
    logic [LEN_ADDR-1:0] ptr;
    logic [LEN_ADDR:0]   remaining;
    logic                inflight;
    logic                inflight_last;
    logic                cmd_ready_q;
    logic [1:0]          occ;
    logic                head_valid;
    logic                pop;
    logic                issue;
    logic [2:0]          credit_used;

    // Issue must see this cycle's pop, so the enable is combinational off registered state.
    assign pop         = head_valid && bus.out_ready;
    assign credit_used = {1'b0, occ} + {2'b00, inflight};
    assign issue       = (state == RUN) && (credit_used < (3'd2 + {2'b00, pop}));

    assign bus.bram_enb   = issue;
    assign bus.bram_addrb = ptr;
    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.out_valid  = head_valid;

    reader_skid_fifo #(
        .LEN_DATA(LEN_DATA)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (inflight),
        .push_last (inflight_last),
        .push_data (bus.bram_doutb),
        .pop       (pop),
        .head_valid(head_valid),
        .head_last (bus.out_last),
        .head_data (bus.out_data),
        .occupancy (occ)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            ptr           <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            cmd_ready_q   <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && (remaining == CNT_ONE);
            if (issue) begin
                ptr       <= ptr + ADDR_ONE;
                remaining <= remaining - CNT_ONE;
            end
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        ptr       <= bus.cmd_addr;
                        remaining <= bus.cmd_len;
                        if (bus.cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state       <= RUN;
                            cmd_ready_q <= 1'b0;
                            busy        <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue && (remaining == CNT_ONE)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && bus.out_last) begin
                        state       <= IDLE;
                        cmd_ready_q <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: table of commands plus hand-written corner sequences.
module tb_bram_stream_reader;
    localparam int unsigned LD    = 32;
    localparam int unsigned LA    = 10;
    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    logic resetn;
    logic busy;
    logic done;

    always #5 clk = ~clk;

    bram_stream_reader_if #(.LEN_DATA(LD), .LEN_ADDR(LA)) bus ();

    bram_stream_reader #(.LEN_DATA(LD), .LEN_ADDR(LA)) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    logic [LD-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.bram_enb) bus.bram_doutb <= mem[bus.bram_addrb];
    end

    int unsigned ncmp = 0;
    int unsigned nerr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [LD-1:0] data;
        logic          last;
    } exp_t;
    exp_t exp_q[$];

    int            cyc         = 0;
    int            first_enb   = -1;
    int            last_enb    = -1;
    int            first_valid = -1;
    int            done_cyc    = -1;
    int unsigned   enb_cnt     = 0;
    int unsigned   hs_cnt      = 0;
    int unsigned   done_cnt    = 0;
    int unsigned   valid_cnt   = 0;
    int unsigned   issued_tot  = 0;
    int unsigned   hs_tot      = 0;
    logic          prev_stall  = 1'b0;
    logic [LD-1:0] prev_data   = '0;
    logic          prev_last   = 1'b0;
    logic [LD-1:0] last_word   = '0;

    // Monitor samples one time unit after the falling edge, once stimulus for the cycle has settled.
    always @(negedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (!resetn) begin
            prev_stall = 1'b0;
            issued_tot = 0;
            hs_tot     = 0;
        end else begin
            if (busy) chk("outstanding_gt2", 64'((issued_tot - hs_tot) > 2), 64'(0));
            if (prev_stall) begin
                chk("stall_valid", 64'(bus.out_valid), 64'(1));
                chk("stall_data", 64'(bus.out_data), 64'(prev_data));
                chk("stall_last", 64'(bus.out_last), 64'(prev_last));
            end
            if (bus.bram_enb) begin
                enb_cnt++;
                issued_tot++;
                if (first_enb < 0) first_enb = cyc;
                last_enb = cyc;
            end
            if (bus.out_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (bus.out_valid && bus.out_ready) begin
                hs_cnt++;
                hs_tot++;
                if (exp_q.size() == 0) begin
                    ncmp++;
                    nerr++;
                    $display("FAIL extra_word: got %0h, expected no word", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", 64'(bus.out_data), 64'(e.data));
                    chk("word_last", 64'(bus.out_last), 64'(e.last));
                end
                if (bus.out_last) last_word = bus.out_data;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    task automatic clear_stats();
        first_enb   = -1;
        last_enb    = -1;
        first_valid = -1;
        done_cyc    = -1;
        enb_cnt     = 0;
        hs_cnt      = 0;
        done_cnt    = 0;
        valid_cnt   = 0;
    endtask

    function automatic logic ready_at(input int unsigned mode, input int unsigned k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 4 == 0) || (k % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run_cmd(input logic [LA-1:0] a, input logic [LA:0] n, input int unsigned mode,
                           input logic [LD-1:0] exp_last, input string tag);
        int          acc;
        int unsigned k;
        int unsigned budget;
        for (int unsigned i = 0; i < n; i++) begin
            exp_q.push_back('{data: LD'((a + i) % DEPTH), last: (i == n - 1)});
        end
        clear_stats();
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = n;
        bus.out_ready = ready_at(mode, 0);
        #2;
        acc = cyc;
        chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
        k      = 1;
        budget = 32'(n) * 4 + 20;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            bus.out_ready = ready_at(mode, k);
            k++;
        end
        repeat (2) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            bus.out_ready = 1'b1;
        end
        #2;
        if (done_cnt == 0) begin
            ncmp++;
            nerr++;
            $display("FAIL %s_timeout: got no done, expected done within %0d cycles", tag, budget);
        end
        chk({tag, "_queue_left"}, 64'(exp_q.size()), 64'(0));
        chk({tag, "_enb_count"}, 64'(enb_cnt), 64'(n));
        chk({tag, "_handshakes"}, 64'(hs_cnt), 64'(n));
        chk({tag, "_last_word"}, 64'(last_word), 64'(exp_last));
        chk({tag, "_done_count"}, 64'(done_cnt), 64'(1));
        chk({tag, "_busy_after"}, 64'(busy), 64'(0));
        chk({tag, "_ready_after"}, 64'(bus.cmd_ready), 64'(1));
        if (mode == 0) begin
            chk({tag, "_first_enb_cyc"}, 64'(first_enb - acc), 64'(1));
            chk({tag, "_last_enb_cyc"}, 64'(last_enb - acc), 64'(n));
            chk({tag, "_first_valid_cyc"}, 64'(first_valid - acc), 64'(3));
            chk({tag, "_done_cyc"}, 64'(done_cyc - acc), 64'(32'(n) + 3));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
        chk({tag, "_enb"}, 64'(bus.bram_enb), 64'(0));
        chk({tag, "_addrb"}, 64'(bus.bram_addrb), 64'(0));
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
        chk({tag, "_out_data"}, 64'(bus.out_data), 64'(0));
        chk({tag, "_out_last"}, 64'(bus.out_last), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
    endtask

    typedef struct {
        logic [LA-1:0] addr;
        logic [LA:0]   len;
        int unsigned   mode;
        logic [LD-1:0] last;
        string         tag;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int acc;
        vecs[0] = '{addr: 10'h010, len: 11'd4,    mode: 0, last: 32'h013, tag: "base010"};
        vecs[1] = '{addr: 10'h3FE, len: 11'd4,    mode: 0, last: 32'h001, tag: "wrap"};
        vecs[2] = '{addr: 10'h020, len: 11'd8,    mode: 1, last: 32'h027, tag: "toggle"};
        vecs[3] = '{addr: 10'h200, len: 11'd1024, mode: 0, last: 32'h1FF, tag: "full"};
        vecs[4] = '{addr: 10'h3FF, len: 11'd1,    mode: 2, last: 32'h3FF, tag: "single"};
        vecs[5] = '{addr: 10'h100, len: 11'd5,    mode: 2, last: 32'h104, tag: "random"};

        for (int i = 0; i < int'(DEPTH); i++) mem[i] = LD'(i);
        resetn        = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk_reset_outputs("reset");
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_cmd(vecs[i].addr, vecs[i].len, vecs[i].mode, vecs[i].last, vecs[i].tag);
        end

        // Zero-length command: done one cycle after accept, no BRAM traffic, never leaves IDLE.
        clear_stats();
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 10'h055;
        bus.cmd_len   = '0;
        #2;
        acc = cyc;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #2;
        chk("len0_ready_c1", 64'(bus.cmd_ready), 64'(1));
        chk("len0_done_c1", 64'(done), 64'(1));
        chk("len0_busy_c1", 64'(busy), 64'(0));
        @(negedge clk);
        #2;
        chk("len0_done_c2", 64'(done), 64'(0));
        chk("len0_ready_c2", 64'(bus.cmd_ready), 64'(1));
        repeat (2) @(negedge clk);
        #2;
        chk("len0_enb_count", 64'(enb_cnt), 64'(0));
        chk("len0_valid_count", 64'(valid_cnt), 64'(0));
        chk("len0_done_count", 64'(done_cnt), 64'(1));
        chk("len0_done_cyc", 64'(done_cyc - acc), 64'(1));

        // Reset mid-RUN with the FIFO holding two words; the following command must stream only its own.
        clear_stats();
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 10'h080;
        bus.cmd_len   = 11'd8;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        chk("stall_buffered_valid", 64'(bus.out_valid), 64'(1));
        chk("stall_buffered_head", 64'(bus.out_data), 64'(32'h080));
        chk("stall_enb_count", 64'(enb_cnt), 64'(2));
        chk("stall_busy", 64'(busy), 64'(1));
        #1;
        resetn = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset");
        exp_q.delete();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        run_cmd(10'h300, 11'd2, 0, 32'h301, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1);
    end
endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side engine for the byte-write dual-port BRAM: accepts a (base address, length) command, walks the BRAM read port with correctly timed `enb`/`addrb` strobes, and delivers the words as a valid/ready stream with `out_last`. It absorbs the BRAM's one-cycle registered read latency and full downstream backpressure without dropping or duplicating words. It sits between a BRAM instance (port B) and any stream consumer, such as a DMA/AXI read-response path or a trace dumper.

## Interface
- `LEN_DATA`, default 32: word width; must match the BRAM.
- `LEN_ADDR`, default 10: BRAM address width; `DEPTH = 2**LEN_ADDR`.
- `clk` input 1: single clock, also drives BRAM port B.
- `resetn` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_addr` input LEN_ADDR: first word address.
- `cmd_len` input LEN_ADDR+1: word count, 0..DEPTH.
- `bram_enb` output 1: BRAM port B enable.
- `bram_addrb` output LEN_ADDR: BRAM port B address.
- `bram_doutb` input LEN_DATA: BRAM read data, valid the cycle after `bram_enb`.
- `out_valid` output 1: stream word valid.
- `out_ready` input 1: consumer ready.
- `out_data` output LEN_DATA: stream word.
- `out_last` output 1: marks the final word of the command.
- `busy` output 1: command in progress.
- `done` output 1: one-cycle pulse after the last word handshake, or after a zero-length command.

## Operation
- States are IDLE, RUN and DRAIN.
- IDLE: `cmd_ready`=1. On accept, latch the address pointer and remaining count.
  - `cmd_len`=0: stay in IDLE and pulse `done` next cycle, with no BRAM access and no stream word.
  - Otherwise go to RUN.
- RUN: issue a read (`bram_enb`=1, `bram_addrb`=pointer) when `occupancy + inflight - pop < 2`:
  - occupancy: entries in the 2-entry output FIFO.
  - inflight: 1 if a read was issued last cycle.
  - pop: `out_valid && out_ready` this cycle.
- Each issue increments the pointer modulo DEPTH (wraps DEPTH-1 → 0) and decrements the issue count. When the issue count reaches 0, go to DRAIN.
- The cycle after each issue, `bram_doutb` is written into the FIFO. It is tagged last if it was the final issued address.
- DRAIN: no issues. On the handshake of the tagged-last word, return to IDLE and pulse `done`.
- FIFO occupancy never exceeds 2; the credit rule guarantees this. Push and pop in the same cycle is legal at any occupancy.
- `out_data`, `out_last` and `out_valid` come from the FIFO head. They hold stable while `out_valid && !out_ready`.
- `cmd_ready`=0 outside IDLE. Commands are not queued.
- `bram_enb`=0 whenever no read is issued. `bram_addrb` is don't-care then, but is held at the pointer.
- Reset (asynchronous, any time):
  - State returns to IDLE and the FIFO is emptied; any in-flight read is discarded.
  - Outputs reset to `cmd_ready`=1, and 0 for `bram_enb`, `bram_addrb`, `out_valid`, `out_data`, `out_last`, `busy` and `done`.

## Timing
- Accept at cycle c → first `bram_enb` at c+1 → data on `bram_doutb` at c+2 → `out_valid` at c+3.
- With `out_ready` held high, throughput is 1 word/cycle. A command of N words completes its last handshake at c+N+2, with `done` at c+N+3 and `cmd_ready` at c+N+3.
- `busy`=1 from c+1 until the cycle `done` is asserted (inclusive of the last handshake cycle).
- Backpressure: at most 2 reads are outstanding or buffered. Stalling `out_ready` stops `bram_enb` within 1 cycle.
- Port B read-during-write with port A returns whatever the BRAM returns; no ordering is enforced here.

## Structure
- Package `bram_reader_pkg`: state enum `reader_state_e` {IDLE, RUN, DRAIN} and the `FIFO_DEPTH`=2 constant.
- Sub-module `reader_skid_fifo`: 2-entry synchronous FIFO of {last, data} with push/pop/occupancy, reset on `resetn`.
- The top level holds the FSM, pointer, counters and credit logic.

## Test plan
- Base 0x010, len 4, `out_ready`=1, BRAM preloaded with word = address → stream 0x010..0x013, `out_last` on 0x013 only, and `bram_enb` high for exactly 4 consecutive cycles.
- Base 0x3FE, len 4 (`LEN_ADDR`=10) → addresses 0x3FE, 0x3FF, 0x000, 0x001 in order (wrap-around).
- Len 8 with `out_ready` toggling 1,0,0,1 repeating → all 8 words delivered in order, no duplicates, data stable while stalled, and FIFO occupancy never above 2.
- Len 0 → `cmd_ready` stays 1, no `bram_enb`, no `out_valid`, `done` pulses one cycle after accept.
- Len 1024 (full DEPTH) from 0x200 → 1024 words, last word is address 0x1FF, `done` once.
- Deassert `resetn` mid-RUN with 2 words buffered → outputs go to reset values immediately; a new len 2 command afterwards streams only its own 2 words.
